// File: rtl/dsk_prefetch_pkg.sv
// rtl/dsk_prefetch_pkg.sv - shared types and constants for the disk track prefetcher
package dsk_prefetch_pkg;

    // Fetch/serve state; encoding is fixed so it can be probed from the outside.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        STREAM = 2'd2
    } dsk_state_t;

    // Byte presented when nothing valid is available (reset, underrun).
    localparam logic [7:0] FILL_BYTE = 8'hFF;

    // Width of the FIFO level counter; covers a full FIFO at the maximum depth of 32.
    localparam int LEVEL_W = 6;

    // Pointer width for a power-of-two FIFO; a depth-1 FIFO still gets one bit.
    function automatic int fifoPtrW(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dsk_word_fifo.sv
// rtl/dsk_word_fifo.sv - DEPTH x 16 synchronous word FIFO with flush and level output
//
// Ports:
//   clk, _reset          clock, asynchronous active-low reset
//   flush                drop all content (wins over push/pop in the same clk)
//   push, pushData       write one word when not full
//   pop                  discard the head word when not empty
//   headData             current head word (valid while not empty)
//   level, full, empty   occupancy
module dsk_word_fifo
    import dsk_prefetch_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic               clk,
    input  logic               _reset,
    input  logic               flush,
    input  logic               push,
    input  logic [15:0]        pushData,
    input  logic               pop,
    output logic [15:0]        headData,
    output logic [LEVEL_W-1:0] level,
    output logic               full,
    output logic               empty
);

    localparam int PW = fifoPtrW(DEPTH);

    logic [15:0]        mem [DEPTH];
    logic [PW-1:0]      wrPtr;
    logic [PW-1:0]      rdPtr;
    logic               doPush;
    logic               doPop;

    assign full     = (level == LEVEL_W'(DEPTH));
    assign empty    = (level == '0);
    assign doPush   = push && !full && !flush;
    assign doPop    = pop && !empty && !flush;
    assign headData = mem[rdPtr];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            level <= '0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            level <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + PW'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + PW'(1);
            end
            level <= level + LEVEL_W'(doPush) - LEVEL_W'(doPop);
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= pushData;
        end
    end

endmodule

// File: rtl/dsk_track_prefetch.sv
// rtl/dsk_track_prefetch.sv - fetches one disk track from RAM and streams it as bytes
//
// Ports:
//   clk, _reset                      clock, asynchronous active-low reset
//   memoryLatch, dskReadAck          extra-bus slot handshake; capture on both high
//   memoryDataIn                     RAM read word
//   dskReadAddr                      byte offset into the disk image, stable per slot
//   trackStart, trackBase, trackLen  load a track and restart fetching
//   trackStop                        abort to IDLE
//   byteReq, byteOut, byteValid      byte stream to the drive model, MSB first
//   underrun                         byte requested while streaming with no data
//   busy, fifoLevel                  status
//   underrunCount                    saturating underrun counter (DSK_PREFETCH_STATS_EN only)
module dsk_track_prefetch
    import dsk_prefetch_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int PRIME_WORDS = 2
) (
    input  logic        clk,
    input  logic        _reset,
    input  logic        memoryLatch,
    input  logic        dskReadAck,
    input  logic [15:0] memoryDataIn,
    output logic [21:0] dskReadAddr,
    input  logic        trackStart,
    input  logic        trackStop,
    input  logic [21:0] trackBase,
    input  logic [15:0] trackLen,
    input  logic        byteReq,
    output logic [7:0]  byteOut,
    output logic        byteValid,
    output logic        underrun,
    output logic        busy,
    output logic [5:0]  fifoLevel
`ifdef DSK_PREFETCH_STATS_EN
    ,
    output logic [15:0] underrunCount
`endif
);

    dsk_state_t  state;
    dsk_state_t  nextState;

    logic [21:0] baseAddr;
    logic [15:0] lenEven;
    logic [15:0] offset;
    logic        phase;

    logic        ctrlEvent;
    logic        fetching;
    logic        capture;
    logic        serveOk;
    logic        serve;
    logic        starve;
    logic        fifoFull;
    logic        fifoEmpty;
    logic [15:0] headData;
    logic        unusedBits;

    // Addresses are word aligned; the low bits of base and length are dropped.
    assign unusedBits = trackBase[0] ^ trackLen[0];

    assign busy      = (state != IDLE);
    assign ctrlEvent = trackStart || trackStop;
    assign fetching  = (state == PRIME) || (state == STREAM);
    // A slot that lands on a start/stop clk is discarded along with the old track.
    assign capture   = dskReadAck && memoryLatch && fetching && !fifoFull && !ctrlEvent;
    assign serveOk   = (state == STREAM) && byteReq && !ctrlEvent;
    assign serve     = serveOk && !fifoEmpty;
    assign starve    = serveOk && fifoEmpty;

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        if (trackStart) begin
            nextState = (trackLen[15:1] != 15'd0) ? PRIME : IDLE;
        end else if (trackStop) begin
            nextState = IDLE;
        end else if ((state == PRIME) && (fifoLevel >= LEVEL_W'(PRIME_WORDS))) begin
            nextState = STREAM;
        end
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            baseAddr    <= '0;
            lenEven     <= '0;
            offset      <= '0;
            dskReadAddr <= '0;
            phase       <= 1'b0;
            byteOut     <= FILL_BYTE;
            byteValid   <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            byteValid <= serve;
            underrun  <= starve;
            if (trackStart) begin
                baseAddr    <= {trackBase[21:1], 1'b0};
                lenEven     <= {trackLen[15:1], 1'b0};
                dskReadAddr <= {trackBase[21:1], 1'b0};
                offset      <= '0;
                phase       <= 1'b0;
            end else if (trackStop) begin
                phase <= 1'b0;
            end else if (capture) begin
                // Last word of the track: rewind to emulate continuous rotation.
                if (offset == lenEven - 16'd2) begin
                    offset      <= '0;
                    dskReadAddr <= baseAddr;
                end else begin
                    offset      <= offset + 16'd2;
                    dskReadAddr <= dskReadAddr + 22'd2;
                end
            end
            if (serve) begin
                byteOut <= phase ? headData[7:0] : headData[15:8];
                phase   <= ~phase;
            end else if (starve) begin
                byteOut <= FILL_BYTE;
            end
        end
    end

`ifdef DSK_PREFETCH_STATS_EN
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            underrunCount <= '0;
        end else if (trackStart) begin
            underrunCount <= '0;
        end else if (starve && (underrunCount != 16'hFFFF)) begin
            underrunCount <= underrunCount + 16'd1;
        end
    end
`else
    // Statistics disabled: no underrun counter.
`endif

    dsk_word_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        ._reset   (_reset),
        .flush    (ctrlEvent),
        .push     (capture),
        .pushData (memoryDataIn),
        .pop      (serve && phase),
        .headData (headData),
        .level    (fifoLevel),
        .full     (fifoFull),
        .empty    (fifoEmpty)
    );

endmodule
